// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared types and constants for the seven-segment display conversion path.
//   conv_state_t : converter sequencing states (IDLE, SHIFT, DONE)
//   chan_t       : display channel identifier (CH_X, CH_Y)
//   SIGN_NEG/POS : sign nibble shown in the top digit of a display word
//   BCD_W/BIN_W  : converter result / input magnitude widths
//   DIV_END_DEF  : default refresh divider terminal count
//   add3_digits  : double-dabble correction step (+3 on every digit >= 5)
// ---------------------------------------------------------------------------
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    typedef enum logic {
        CH_X = 1'b0,
        CH_Y = 1'b1
    } chan_t;

    localparam logic [3:0]  SIGN_NEG    = 4'hF;
    localparam logic [3:0]  SIGN_POS    = 4'h0;
    localparam int          BCD_W       = 12;
    localparam int          BIN_W       = 9;
    localparam logic [15:0] DIV_END_DEF = 16'hC350;

    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int d = 0; d < BCD_W / 4; d++) begin
            if (bcd[d*4 +: 4] >= 4'd5) begin
                res[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter, one iteration per cycle.
//   CLK     in  : system clock
//   RST     in  : synchronous active-low reset
//   load    in  : start a conversion of bin_in (clears BCD and iteration count)
//   bin_in  in  : magnitude to convert, 0..511
//   done    out : high during the cycle that performs the final (9th) iteration;
//                 bcd_out holds the result from the following cycle on
//   bcd_out out : three BCD digits of the converted magnitude
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [BIN_W-1:0] bin_in,
    output logic             done,
    output logic [BCD_W-1:0] bcd_out
);

    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

    logic [BIN_W-1:0]       bin_q;
    logic [BCD_W-1:0]       bcd_q;
    logic [3:0]             iter_q;
    logic                   run_q;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Correct the digits first, then shift the whole {bcd, bin} pair left.
    // The top BCD bit falls off, which is harmless for magnitudes <= 511.
    assign shifted = {add3_digits(bcd_q), bin_q} << 1;
    assign done    = run_q && (iter_q == LAST_ITER);
    assign bcd_out = bcd_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else if (load) begin
            bin_q  <= bin_in;
            bcd_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            bcd_q  <= shifted[BCD_W+BIN_W-1:BIN_W];
            bin_q  <= shifted[BIN_W-1:0];
            iter_q <= iter_q + 4'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bcd_conv_arb.sv
// ---------------------------------------------------------------------------
// bcd_conv_arb
// Shares one sequential binary-to-BCD converter between the x and y display
// channels. Each refresh tick snapshots both sign-magnitude samples and marks
// both channels pending; a round-robin arbiter feeds them through the
// converter one at a time and publishes a 16-bit display word per channel.
//   DIV_END   param : refresh divider terminal count (tick every DIV_END+1 cycles)
//   CLK       in    : system clock
//   RST       in    : synchronous active-low reset
//   x_DIN     in    : x sample, [9] sign (1 = negative), [8:0] magnitude
//   y_DIN     in    : y sample, same format
//   x_bcdData out   : {sign nibble (F = negative), three BCD digits}
//   y_bcdData out   : same format for y
//   x_upd     out   : one-cycle pulse when x_bcdData first shows a new value
//   y_upd     out   : one-cycle pulse when y_bcdData first shows a new value
//   busy      out   : converter in SHIFT or DONE
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; grants a pending channel and loads the converter
// SHIFT | converter running its nine add-3/shift iterations
// DONE  | result ready; write the granted channel's word and pulse its upd
// ---------------------------------------------------------------------------
module bcd_conv_arb
    import ssd_pkg::*;
#(
    parameter logic [15:0] DIV_END = DIV_END_DEF
)
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  x_DIN,
    input  logic [9:0]  y_DIN,
    output logic [15:0] x_bcdData,
    output logic [15:0] y_bcdData,
    output logic        x_upd,
    output logic        y_upd,
    output logic        busy
);

    conv_state_t      state_q, state_d;
    logic [15:0]      div_q;
    logic             tick;
    logic [9:0]       x_snap, y_snap;
    logic             x_pend, y_pend;
    chan_t            last_q;
    chan_t            gnt_q;
    chan_t            gnt_sel;
    logic             sign_q;
    logic             load;
    logic [BIN_W-1:0] load_bin;
    logic             conv_done;
    logic [BCD_W-1:0] conv_bcd;

    // Refresh divider
    assign tick = (div_q == DIV_END);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 16'd1;
        end
    end

    // Next-state, grant and converter load
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        gnt_sel = CH_X;
        case (state_q)
            IDLE: begin
                if (x_pend || y_pend) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                    if (x_pend && y_pend) begin
                        gnt_sel = (last_q == CH_Y) ? CH_X : CH_Y;
                    end else begin
                        gnt_sel = x_pend ? CH_X : CH_Y;
                    end
                end
            end
            SHIFT: begin
                if (conv_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The grant loads the snapshot currently held; a coincident tick only
    // replaces the snapshot for the next conversion.
    assign load_bin = (gnt_sel == CH_X) ? x_snap[BIN_W-1:0] : y_snap[BIN_W-1:0];
    assign busy     = (state_q == SHIFT) || (state_q == DONE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Snapshots, pends and round-robin bookkeeping. The tick set wins over
    // the grant clear.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            x_snap <= '0;
            y_snap <= '0;
            x_pend <= 1'b0;
            y_pend <= 1'b0;
            last_q <= CH_Y;
            gnt_q  <= CH_X;
            sign_q <= 1'b0;
        end else begin
            if (tick) begin
                x_snap <= x_DIN;
                y_snap <= y_DIN;
                x_pend <= 1'b1;
                y_pend <= 1'b1;
            end else if (load) begin
                if (gnt_sel == CH_X) begin
                    x_pend <= 1'b0;
                end else begin
                    y_pend <= 1'b0;
                end
            end
            if (load) begin
                last_q <= gnt_sel;
                gnt_q  <= gnt_sel;
                // Sign is captured with the magnitude so a later tick cannot
                // pair a new sign with an in-flight magnitude.
                sign_q <= (gnt_sel == CH_X) ? x_snap[9] : y_snap[9];
            end
        end
    end

    // Output registers
    always_ff @(posedge CLK) begin
        if (!RST) begin
            x_bcdData <= '0;
            y_bcdData <= '0;
            x_upd     <= 1'b0;
            y_upd     <= 1'b0;
        end else begin
            x_upd <= 1'b0;
            y_upd <= 1'b0;
            if (state_q == DONE) begin
                if (gnt_q == CH_X) begin
                    x_bcdData <= {sign_q ? SIGN_NEG : SIGN_POS, conv_bcd};
                    x_upd     <= 1'b1;
                end else begin
                    y_bcdData <= {sign_q ? SIGN_NEG : SIGN_POS, conv_bcd};
                    y_upd     <= 1'b1;
                end
            end
        end
    end

    bin2bcd_seq u_conv (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .bin_in  (load_bin),
        .done    (conv_done),
        .bcd_out (conv_bcd)
    );

endmodule

// File: tb/tb_bcd_conv_arb.sv
module tb_bcd_conv_arb;

    logic        CLK = 1'b0;
    logic        RST, rst_f;
    logic [9:0]  x_DIN, y_DIN, xf_din, yf_din;
    logic [15:0] x_bcdData, y_bcdData, xf_bcd, yf_bcd;
    logic        x_upd, y_upd, busy, xf_upd, yf_upd, busy_f;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;

    bcd_conv_arb #(.DIV_END(16'd31)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .x_DIN     (x_DIN),
        .y_DIN     (y_DIN),
        .x_bcdData (x_bcdData),
        .y_bcdData (y_bcdData),
        .x_upd     (x_upd),
        .y_upd     (y_upd),
        .busy      (busy)
    );

    bcd_conv_arb #(.DIV_END(16'd10)) dut_f (
        .CLK       (CLK),
        .RST       (rst_f),
        .x_DIN     (xf_din),
        .y_DIN     (yf_din),
        .x_bcdData (xf_bcd),
        .y_bcdData (yf_bcd),
        .x_upd     (xf_upd),
        .y_upd     (yf_upd),
        .busy      (busy_f)
    );

    // Reference: sign nibble plus decimal digits of the magnitude.
    function automatic logic [15:0] ref_word(input logic [9:0] v);
        int m;
        m = int'(v[8:0]);
        return {v[9] ? 4'hF : 4'h0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Cycle bookkeeping: cyc is the index of the cycle being sampled (negedge).
    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        cyc += n;
    endtask

    task automatic goto_cyc(input int c);
        if (c > cyc) step(c - cyc);
    endtask

    task automatic test_reset();
        checks++; if (x_bcdData !== 16'h0000) begin errors++; $display("FAIL reset_x_bcd: got %h want 0000", x_bcdData); end
        checks++; if (y_bcdData !== 16'h0000) begin errors++; $display("FAIL reset_y_bcd: got %h want 0000", y_bcdData); end
        checks++; if (x_upd !== 1'b0) begin errors++; $display("FAIL reset_x_upd: got %b want 0", x_upd); end
        checks++; if (y_upd !== 1'b0) begin errors++; $display("FAIL reset_y_upd: got %b want 0", y_upd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        x_DIN = 10'h1FF;
        y_DIN = 10'h27B;
        RST   = 1'b1;
        cyc   = 0;
    endtask

    // First tick at cycle 31: full per-cycle waveform of busy and the upd pulses.
    task automatic test_basic();
        logic eb;
        goto_cyc(31);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_pre: got %b want 0", busy); end
        checks++; if (x_bcdData !== 16'h0000) begin errors++; $display("FAIL basic_x_pre: got %h want 0000", x_bcdData); end
        for (int c = 32; c <= 55; c++) begin
            goto_cyc(c);
            eb = ((c >= 33) && (c <= 42)) || ((c >= 44) && (c <= 53));
            checks++; if (busy !== eb) begin errors++; $display("FAIL basic_busy c=%0d: got %b want %b", c, busy, eb); end
            checks++; if (x_upd !== (c == 43)) begin errors++; $display("FAIL basic_x_upd c=%0d: got %b want %b", c, x_upd, c == 43); end
            checks++; if (y_upd !== (c == 54)) begin errors++; $display("FAIL basic_y_upd c=%0d: got %b want %b", c, y_upd, c == 54); end
            if (c == 43) begin
                checks++; if (x_bcdData !== ref_word(10'h1FF)) begin errors++; $display("FAIL basic_x_val: got %h want %h", x_bcdData, ref_word(10'h1FF)); end
            end
            if (c == 54) begin
                checks++; if (y_bcdData !== ref_word(10'h27B)) begin errors++; $display("FAIL basic_y_val: got %h want %h", y_bcdData, ref_word(10'h27B)); end
                checks++; if (x_bcdData !== ref_word(10'h1FF)) begin errors++; $display("FAIL basic_x_hold: got %h want %h", x_bcdData, ref_word(10'h1FF)); end
            end
        end
    endtask

    // Ticks at 63 and 95: negative zero, zero, and digit-rollover values.
    task automatic test_boundary();
        logic [9:0] xv [2];
        logic [9:0] yv [2];
        int t;
        xv[0] = 10'h200; yv[0] = 10'h000;
        xv[1] = 10'h063; yv[1] = 10'h064;
        for (int k = 0; k < 2; k++) begin
            t = 63 + 32 * k;
            goto_cyc(t - 7);
            x_DIN = xv[k];
            y_DIN = yv[k];
            goto_cyc(t + 12);
            checks++; if (x_bcdData !== ref_word(xv[k]) || x_upd !== 1'b1) begin errors++; $display("FAIL boundary_x k=%0d: got %h upd %b want %h upd 1", k, x_bcdData, x_upd, ref_word(xv[k])); end
            goto_cyc(t + 23);
            checks++; if (y_bcdData !== ref_word(yv[k]) || y_upd !== 1'b1) begin errors++; $display("FAIL boundary_y k=%0d: got %h upd %b want %h upd 1", k, y_bcdData, y_upd, ref_word(yv[k])); end
        end
    endtask

    // Tick at 127 takes x=005; x changes at T+5 and only the next tick (159) sees it.
    task automatic test_midchange();
        goto_cyc(120);
        x_DIN = 10'h005;
        y_DIN = 10'h3FF;
        goto_cyc(132);
        x_DIN = 10'h1F4;
        goto_cyc(138);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_done: got %b want 1", busy); end
        goto_cyc(139);
        checks++; if (x_bcdData !== ref_word(10'h005) || x_upd !== 1'b1) begin errors++; $display("FAIL mid_x_old: got %h upd %b want %h upd 1", x_bcdData, x_upd, ref_word(10'h005)); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_idle: got %b want 0", busy); end
        goto_cyc(140);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_y: got %b want 1", busy); end
        goto_cyc(150);
        checks++; if (y_bcdData !== ref_word(10'h3FF) || y_upd !== 1'b1) begin errors++; $display("FAIL mid_y: got %h upd %b want %h upd 1", y_bcdData, y_upd, ref_word(10'h3FF)); end
        goto_cyc(171);
        checks++; if (x_bcdData !== ref_word(10'h1F4) || x_upd !== 1'b1) begin errors++; $display("FAIL mid_x_new: got %h upd %b want %h upd 1", x_bcdData, x_upd, ref_word(10'h1F4)); end
    endtask

    // Reset pulse at T+6 (x mid-shift) of the tick at 191.
    task automatic test_reset_mid();
        goto_cyc(176);
        x_DIN = 10'h2A5;
        y_DIN = 10'h0C8;
        goto_cyc(197);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        RST = 1'b0;
        step(1);
        checks++; if (x_bcdData !== 16'h0000 || y_bcdData !== 16'h0000) begin errors++; $display("FAIL rmid_outputs: got %h %h want 0000 0000", x_bcdData, y_bcdData); end
        checks++; if (busy !== 1'b0 || x_upd !== 1'b0 || y_upd !== 1'b0) begin errors++; $display("FAIL rmid_flags: got busy %b upd %b%b want 0 00", busy, x_upd, y_upd); end
        RST = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 54; c++) begin
            goto_cyc(c);
            checks++; if (x_upd !== (c == 43)) begin errors++; $display("FAIL rmid_x_upd c=%0d: got %b want %b", c, x_upd, c == 43); end
            checks++; if (y_upd !== (c == 54)) begin errors++; $display("FAIL rmid_y_upd c=%0d: got %b want %b", c, y_upd, c == 54); end
            if (c < 43) begin
                checks++; if (x_bcdData !== 16'h0000) begin errors++; $display("FAIL rmid_x_hold c=%0d: got %h want 0000", c, x_bcdData); end
            end
        end
        checks++; if (x_bcdData !== ref_word(10'h2A5)) begin errors++; $display("FAIL rmid_x_val: got %h want %h", x_bcdData, ref_word(10'h2A5)); end
        checks++; if (y_bcdData !== ref_word(10'h0C8)) begin errors++; $display("FAIL rmid_y_val: got %h want %h", y_bcdData, ref_word(10'h0C8)); end
    endtask

    // Every x magnitude/sign combination, random y, one tick each.
    task automatic test_random();
        int t;
        logic [9:0] yv;
        for (int i = 0; i < 1024; i++) begin
            t = 63 + 32 * i;
            goto_cyc(t - 6);
            x_DIN = 10'(i);
            yv    = 10'($urandom);
            y_DIN = yv;
            goto_cyc(t + 12);
            checks++; if (x_bcdData !== ref_word(10'(i)) || x_upd !== 1'b1) begin errors++; $display("FAIL rand_x i=%0d: got %h upd %b want %h upd 1", i, x_bcdData, x_upd, ref_word(10'(i))); end
            goto_cyc(t + 23);
            checks++; if (y_bcdData !== ref_word(yv) || y_upd !== 1'b1) begin errors++; $display("FAIL rand_y i=%0d: got %h upd %b want %h upd 1", i, y_bcdData, y_upd, ref_word(yv)); end
        end
    endtask

    // DIV_END = 10: channels always pending, so results land every 11 cycles
    // alternating x, y, each from the latest tick before its grant.
    task automatic test_fast();
        logic [9:0] hx [400];
        logic [9:0] hy [400];
        logic       ex, ey;
        int         g, t;
        logic [15:0] ev;
        @(negedge CLK);
        rst_f = 1'b1;
        for (int fc = 0; fc < 400; fc++) begin
            if (fc > 0) @(negedge CLK);
            hx[fc] = 10'($urandom);
            hy[fc] = 10'($urandom);
            xf_din = hx[fc];
            yf_din = hy[fc];
            ex = (fc >= 22) && ((fc - 22) % 11 == 0) && (((fc - 22) / 11) % 2 == 0);
            ey = (fc >= 22) && ((fc - 22) % 11 == 0) && (((fc - 22) / 11) % 2 == 1);
            checks++; if (xf_upd !== ex) begin errors++; $display("FAIL fast_x_upd fc=%0d: got %b want %b", fc, xf_upd, ex); end
            checks++; if (yf_upd !== ey) begin errors++; $display("FAIL fast_y_upd fc=%0d: got %b want %b", fc, yf_upd, ey); end
            if (ex || ey) begin
                g  = fc - 11;
                t  = 10 + 11 * ((g - 11) / 11);
                ev = ex ? ref_word(hx[t]) : ref_word(hy[t]);
                if (ex) begin
                    checks++; if (xf_bcd !== ev) begin errors++; $display("FAIL fast_x_val fc=%0d: got %h want %h", fc, xf_bcd, ev); end
                end else begin
                    checks++; if (yf_bcd !== ev) begin errors++; $display("FAIL fast_y_val fc=%0d: got %h want %h", fc, yf_bcd, ev); end
                end
            end
        end
    endtask

    initial begin
        RST    = 1'b0;
        rst_f  = 1'b0;
        x_DIN  = '0;
        y_DIN  = '0;
        xf_din = '0;
        yf_din = '0;
        repeat (3) @(negedge CLK);
        test_reset();
        test_basic();
        test_boundary();
        test_midchange();
        test_reset_mid();
        test_random();
        test_fast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
